// File: rtl/water_valve_arbiter.sv
// Round-robin arbiter sharing one building water inlet valve between several
// washing-machine controllers. One grant at a time, a one-cycle valve-switch gap
// between grants, and a per-grant fill limit that pulses a time-out to the
// offending machine and locks it out until it drops its request.
module water_valve_arbiter #(
  parameter int unsigned NUM_MACHINES    = 4,
  parameter int unsigned ID_WIDTH        = 2,
  parameter int unsigned MAX_FILL_CYCLES = 8,
  parameter int unsigned CNT_WIDTH       = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_MACHINES-1:0] sig_Water_Request,
  output logic [NUM_MACHINES-1:0] sig_Water_Grant,
  output logic                    valve_Open,
  output logic [NUM_MACHINES-1:0] sig_Time_Out,
  output logic [ID_WIDTH-1:0]     grant_Id,
  output logic [CNT_WIDTH-1:0]    fill_Count
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StGap   = 2'd2
  } state_e;

  localparam logic [ID_WIDTH-1:0]     LastIdRst = ID_WIDTH'(NUM_MACHINES - 1);
  localparam logic [CNT_WIDTH-1:0]    FillMax   = CNT_WIDTH'(MAX_FILL_CYCLES);
  localparam logic [NUM_MACHINES-1:0] OneLsb    = NUM_MACHINES'(1);

  state_e                  state_q, state_d;
  logic [NUM_MACHINES-1:0] grant_q, grant_d;
  logic [NUM_MACHINES-1:0] time_out_q, time_out_d;
  logic [NUM_MACHINES-1:0] lockout_q, lockout_d;
  logic [ID_WIDTH-1:0]     last_id_q, last_id_d;
  logic [CNT_WIDTH-1:0]    fill_count_q, fill_count_d;

  logic [NUM_MACHINES-1:0] eligible;
  logic [ID_WIDTH-1:0]     cand_id;
  logic [ID_WIDTH-1:0]     sel_id;
  logic                    sel_valid;
  logic [NUM_MACHINES-1:0] cur_onehot;

  // A locked machine only becomes eligible after it has been seen with its request low.
  assign eligible   = sig_Water_Request & ~lockout_q;
  assign cur_onehot = OneLsb << last_id_q;

  // Round-robin search: first eligible index upward from last_id+1, wrapping around,
  // ending on last_id itself so a lone requester can be re-granted.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = last_id_q;
    cand_id   = last_id_q;
    for (int unsigned k = 1; k <= NUM_MACHINES; k++) begin
      cand_id = ID_WIDTH'((32'(last_id_q) + k) % NUM_MACHINES);
      if (!sel_valid && eligible[cand_id]) begin
        sel_valid = 1'b1;
        sel_id    = cand_id;
      end
    end
  end

  // Next-state logic for the grant FSM and all registered outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    time_out_d   = '0;
    last_id_d    = last_id_q;
    fill_count_d = '0;
    // Any machine sampled with its request low is released from lockout.
    lockout_d    = lockout_q & sig_Water_Request;

    unique case (state_q)
      StIdle, StGap: begin
        if (sel_valid) begin
          state_d      = StGrant;
          grant_d      = OneLsb << sel_id;
          last_id_d    = sel_id;
          fill_count_d = CNT_WIDTH'(1);
        end else begin
          state_d = StIdle;
        end
      end

      StGrant: begin
        if (!sig_Water_Request[last_id_q]) begin
          // Voluntary release wins over the fill limit.
          state_d = StGap;
        end else if (fill_count_q == FillMax) begin
          state_d    = StGap;
          time_out_d = cur_onehot;
          lockout_d  = lockout_d | cur_onehot;
        end else begin
          // Other requesters never preempt a running grant.
          grant_d      = grant_q;
          fill_count_d = fill_count_q + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset closes the valve immediately with no time-out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      time_out_q   <= '0;
      lockout_q    <= '0;
      last_id_q    <= LastIdRst;
      fill_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      time_out_q   <= time_out_d;
      lockout_q    <= lockout_d;
      last_id_q    <= last_id_d;
      fill_count_q <= fill_count_d;
    end
  end

  assign sig_Water_Grant = grant_q;
  assign valve_Open      = |grant_q;
  assign sig_Time_Out    = time_out_q;
  assign grant_Id        = last_id_q;
  assign fill_Count      = fill_count_q;

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(grant_q));
  a_time_out_onehot0: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(time_out_q));
  a_fill_zero_when_idle: assert property (@(posedge clock) disable iff (!reset_n)
    (grant_q == '0) |-> (fill_count_q == '0));
  a_grant_only_in_grant: assert property (@(posedge clock) disable iff (!reset_n)
    (grant_q != '0) |-> (state_q == StGrant));
`endif

endmodule

// File: tb/tb_water_valve_arbiter.sv
// Scoreboard bench for water_valve_arbiter: stimulus drives requests on the falling
// edge and queues the outputs expected after the next rising edge; a monitor pops and
// compares shortly after each rising edge.
module tb_water_valve_arbiter;

  logic       clock;
  logic       reset_n;
  logic [3:0] sig_Water_Request;
  logic [3:0] sig_Water_Grant;
  logic       valve_Open;
  logic [3:0] sig_Time_Out;
  logic [1:0] grant_Id;
  logic [3:0] fill_Count;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] time_out;
    logic [1:0] id;
    logic [3:0] fill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  water_valve_arbiter #(
    .NUM_MACHINES   (4),
    .ID_WIDTH       (2),
    .MAX_FILL_CYCLES(8),
    .CNT_WIDTH      (4)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .sig_Water_Request(sig_Water_Request),
    .sig_Water_Grant  (sig_Water_Grant),
    .valve_Open       (valve_Open),
    .sig_Time_Out     (sig_Time_Out),
    .grant_Id         (grant_Id),
    .fill_Count       (fill_Count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".grant"},    32'(sig_Water_Grant), 32'(e.grant));
    chk({tag, ".valve"},    32'(valve_Open),      32'(|e.grant));
    chk({tag, ".time_out"}, 32'(sig_Time_Out),    32'(e.time_out));
    chk({tag, ".grant_id"}, 32'(grant_Id),        32'(e.id));
    chk({tag, ".fill"},     32'(fill_Count),      32'(e.fill));
  endtask

  // Called on a falling edge: drive the request sampled at the next rising edge, queue
  // the outputs expected after it, and return on the following falling edge.
  task automatic step(input logic [3:0] req, input logic [3:0] g, input logic [3:0] to,
                      input logic [1:0] id, input logic [3:0] fill);
    exp_t e;
    e.grant    = g;
    e.time_out = to;
    e.id       = id;
    e.fill     = fill;
    sig_Water_Request = req;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: compare registered outputs just after every rising edge that has an entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all("sb", e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    reset_n           = 1'b0;
    sig_Water_Request = 4'b0000;
    repeat (2) @(negedge clock);
    r = '{grant: 4'b0000, time_out: 4'b0000, id: 2'd3, fill: 4'd0};
    chk_all("por", r);
    reset_n = 1'b1;

    // Reset: build a grant to machine 2, then reset mid-grant.
    step(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'd1);
    step(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'd2);
    #1 reset_n = 1'b0;
    #1;
    r = '{grant: 4'b0000, time_out: 4'b0000, id: 2'd3, fill: 4'd0};
    chk_all("rst_mid", r);
    @(negedge clock);
    reset_n = 1'b1;
    step(4'b0001, 4'b0001, 4'b0000, 2'd0, 4'd1);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);

    // Single request held for 5 edges, then released with no time-out.
    for (int i = 1; i <= 5; i++) step(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'(i));
    step(4'b0000, 4'b0000, 4'b0000, 2'd2, 4'd0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd2, 4'd0);

    // Drop coincides with fill limit: drop wins, no time-out.
    for (int i = 1; i <= 8; i++) step(4'b1000, 4'b1000, 4'b0000, 2'd3, 4'(i));
    step(4'b0000, 4'b0000, 4'b0000, 2'd3, 4'd0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd3, 4'd0);

    // Round-robin with all requesting; each holder drops after 3 cycles for one edge.
    for (int m = 0; m < 5; m++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (m % 4);
      step(4'b1111, oh, 4'b0000, 2'(m % 4), 4'd1);
      if (m == 4) break;
      step(4'b1111, oh, 4'b0000, 2'(m % 4), 4'd2);
      step(4'b1111, oh, 4'b0000, 2'(m % 4), 4'd3);
      step(4'b1111 & ~oh, 4'b0000, 4'b0000, 2'(m % 4), 4'd0);
    end
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0);

    // Time-out: machine 1 holds for 20 edges; 8 grant cycles, one pulse, then lockout.
    for (int i = 1; i <= 8; i++) step(4'b0010, 4'b0010, 4'b0000, 2'd1, 4'(i));
    step(4'b0010, 4'b0000, 4'b0010, 2'd1, 4'd0);
    for (int i = 10; i <= 20; i++) step(4'b0010, 4'b0000, 4'b0000, 2'd1, 4'd0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd1, 4'd0);
    step(4'b0010, 4'b0010, 4'b0000, 2'd1, 4'd1);
    step(4'b0000, 4'b0000, 4'b0000, 2'd1, 4'd0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd1, 4'd0);

    // No preemption: machine 2 requests at fill 3 and waits for release plus the gap.
    step(4'b0001, 4'b0001, 4'b0000, 2'd0, 4'd1);
    step(4'b0001, 4'b0001, 4'b0000, 2'd0, 4'd2);
    step(4'b0001, 4'b0001, 4'b0000, 2'd0, 4'd3);
    step(4'b0101, 4'b0001, 4'b0000, 2'd0, 4'd4);
    step(4'b0101, 4'b0001, 4'b0000, 2'd0, 4'd5);
    step(4'b0100, 4'b0000, 4'b0000, 2'd0, 4'd0);
    step(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'd1);
    step(4'b0000, 4'b0000, 4'b0000, 2'd2, 4'd0);
    step(4'b0000, 4'b0000, 4'b0000, 2'd2, 4'd0);

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
